uart_tx_dev: RTL
================

# uart_tx_dev

Memory-mapped UART transmitter peripheral that responds to CPU stores and loads arriving through the system bridge, in the same register-slot style as the timer devices. The CPU queues bytes into an internal FIFO. The block serialises them on a single `txd` line as 8N1 frames: start bit, 8 data bits LSB first, stop bit. It raises a level interrupt toward the bridge's interrupt inputs when the queue has drained.

## Interface
- `CLKS_PER_BIT`, 2604: clock cycles per serial bit (25 MHz / 9600 baud); legal range ≥ 2.
- `FIFO_DEPTH`, 8: byte entries in the transmit queue; power of two, ≥ 2.

Ports:
- `clk`  in  1  single system clock.
- `reset`  in  1  asynchronous, active-high reset.
- `PrAddr`  in  2  register select, taken from bridge device address bits [3:2].
- `WE`  in  1  write strobe for this device, sampled on the rising edge of `clk`.
- `DataIn`  in  32  write data from the bridge.
- `DataOut`  out  32  read data, combinational from `PrAddr`.
- `InterruptRequest`  out  1  level interrupt to the bridge.
- `txd`  out  1  serial output; idles high.

## Operation
Register map, selected by `PrAddr`:
- 0, DATA
  - Write pushes `DataIn[7:0]`; bits [31:8] are ignored.
  - Read returns 0.
- 1, STATUS (read-only; writes are ignored)
  - bit0 busy: FSM is not IDLE.
  - bit1 full.
  - bit2 empty.
  - bit3 overflow: sticky.
  - bits[7:4] fifo count, saturating at 15.
  - all other bits 0.
- 2, CTRL (read/write)
  - bit0 TXEN.
  - bit1 IE.
  - Any write to CTRL clears overflow.
  - Reads return {30'b0, IE, TXEN}.
- 3: reserved. Reads return 0; writes are ignored.

Behaviour:
- Push to DATA while full: the byte is dropped, overflow is set, and the FIFO is unchanged.
- Bytes may be queued while TXEN=0. They are held in the FIFO and not sent until TXEN=1.
- FSM states are IDLE, START, DATA, STOP.
  - IDLE → START when TXEN=1 and the FIFO is not empty. The FIFO head is popped into the shift register and the bit counter is cleared.
  - START → DATA after `CLKS_PER_BIT` cycles.
  - DATA shifts one bit every `CLKS_PER_BIT` cycles, 8 bits total, then → STOP.
  - When STOP ends: if TXEN=1 and the FIFO is not empty, pop and go → START directly; otherwise → IDLE.
- `txd` is 1 in IDLE and STOP, 0 in START, and `shift[0]` in DATA.
- Clearing TXEN in mid-frame does not abort: the current frame completes, then the FSM returns to IDLE.
- `InterruptRequest` = IE & empty & (state==IDLE). It is a level signal and is cleared by pushing a byte or clearing IE.
- A simultaneous push and pop in the same cycle is legal when the FIFO is full. Count is unchanged and no overflow occurs, because the pop frees the slot first.
- The baud counter runs only outside IDLE and reloads at every bit boundary.

## Timing
Reset values:
- `txd`=1.
- `InterruptRequest`=0, because IE=0.
- CTRL=0 and overflow=0.
- FIFO empty with pointers at 0.
- FSM in IDLE.
- `DataOut` shows the registers' reset values.

Reset asserted in mid-frame forces `txd`=1 asynchronously and discards the FIFO contents.

Frame timing:
- With TXEN=1 and the FSM idle, a DATA write at edge E makes the FIFO non-empty after E. At edge E+1 the FSM enters START and `txd` falls.
- Each bit lasts exactly `CLKS_PER_BIT` cycles.
- A frame is 10·`CLKS_PER_BIT` cycles.
- Back-to-back frames have no idle gap between the stop bit and the next start bit.

Register timing:
- STATUS reflects a push one cycle after the write edge.
- Reads have zero wait states.

## Structure
- The shared package holds:
  - register offset constants: DATA=0, STATUS=1, CTRL=2;
  - STATUS and CTRL bit positions;
  - the FSM state encoding.
- One sub-module, `uart_tx_fifo`: a synchronous FIFO with parameter `FIFO_DEPTH`, push/pop ports, full/empty/count outputs, and asynchronous active-high reset.
- The top level holds the register decode, CTRL and overflow flops, the FSM, the baud counter, the bit counter and the shift register.

## Test plan
Benches run with `CLKS_PER_BIT`=4.
- Write CTRL=1, then DATA=0x55.
  - Expect `txd` low at E+1.
  - Then the bits 1,0,1,0,1,0,1,0, each 4 cycles.
  - Then stop=1; the frame totals 40 cycles.
  - STATUS.busy=1 throughout the frame.
- TXEN=0, push 3 bytes, then read STATUS.
  - Expect count=3, empty=0, busy=0, and `txd` held at 1.
  - Set TXEN=1: three frames are sent back-to-back with no gap, 120 cycles in total.
- TXEN=0, push 9 bytes with `FIFO_DEPTH`=8.
  - Expect full=1, overflow=1 and count=8; the 9th byte is never sent.
  - A write to CTRL clears overflow.
- CTRL=3, push 1 byte.
  - `InterruptRequest` is 0 while the byte is queued or being sent.
  - It rises to 1 when STOP returns the FSM to IDLE.
  - Writing CTRL=1 clears it.
- Clear TXEN during the 4th data bit while 2 bytes are queued.
  - The current frame completes.
  - The FSM then goes to IDLE and count=2.
- Assert `reset` mid-frame.
  - `txd`=1 immediately.
  - STATUS reads empty=1 and count=0; CTRL reads 0.

Source files
------------

// File: rtl/uart_tx_dev_pkg.sv
`timescale 1ns/1ps
// Shared definitions for the UART transmitter peripheral: register offsets,
// register bit positions, FSM encoding and a small count helper.
package uart_tx_dev_pkg;

  localparam logic [1:0] ADDR_DATA   = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd1;
  localparam logic [1:0] ADDR_CTRL   = 2'd2;

  localparam int unsigned STAT_BUSY    = 0;
  localparam int unsigned STAT_FULL    = 1;
  localparam int unsigned STAT_EMPTY   = 2;
  localparam int unsigned STAT_OVF     = 3;
  localparam int unsigned STAT_CNT_LSB = 4;

  localparam int unsigned CTRL_TXEN = 0;
  localparam int unsigned CTRL_IE   = 1;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_e;

  // Four-bit view of the FIFO occupancy, pinned at 15 for deep queues.
  function automatic logic [3:0] sat_count(input logic [31:0] c);
    return (c > 32'd15) ? 4'hF : c[3:0];
  endfunction

endpackage

// File: rtl/uart_tx_dev_fifo.sv
`timescale 1ns/1ps
// Byte-wide synchronous FIFO with first-word fall-through output.
// A pop in the same cycle as a push to a full FIFO frees the slot first.
module uart_tx_fifo #(
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          push,
  input  logic                          pop,
  input  logic [7:0]                    din,
  output logic [7:0]                    dout,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(FIFO_DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push, do_pop;

  assign do_pop  = pop && (count_q != '0);
  assign do_push = push && ((count_q != FULL_CNT) || do_pop);

  // Next-state for pointers and occupancy.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are don't-care while unoccupied.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

  assign dout  = mem_q[rd_ptr_q];
  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == '0);
  assign count = count_q;

endmodule

// File: rtl/uart_tx_dev.sv
`timescale 1ns/1ps
// Memory-mapped 8N1 UART transmitter: register slots for DATA/STATUS/CTRL,
// a byte FIFO, and a bit-serialising FSM driving txd.
module uart_tx_dev
  import uart_tx_dev_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 2604,
  parameter int unsigned FIFO_DEPTH   = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  PrAddr,
  input  logic        WE,
  input  logic [31:0] DataIn,
  output logic [31:0] DataOut,
  output logic        InterruptRequest,
  output logic        txd
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

  logic          txen_q, txen_d;
  logic          ie_q, ie_d;
  logic          ovf_q, ovf_d;
  tx_state_e     state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          txd_q, txd_d;

  logic          wr_data, wr_ctrl, bit_done;
  logic          fifo_pop, fifo_full, fifo_empty;
  logic [7:0]    fifo_dout;
  logic [AW:0]   fifo_count;
  logic          unused_data_bits;

  assign wr_data  = WE && (PrAddr == ADDR_DATA);
  assign wr_ctrl  = WE && (PrAddr == ADDR_CTRL);
  assign bit_done = (baud_q == BAUD_LAST);
  assign unused_data_bits = ^DataIn[31:8];

  uart_tx_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (wr_data),
    .pop   (fifo_pop),
    .din   (DataIn[7:0]),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // CTRL and sticky overflow; a pop in the same cycle makes room, so no overflow.
  always_comb begin
    txen_d = txen_q;
    ie_d   = ie_q;
    ovf_d  = ovf_q;
    if (wr_ctrl) begin
      txen_d = DataIn[CTRL_TXEN];
      ie_d   = DataIn[CTRL_IE];
      ovf_d  = 1'b0;
    end else if (wr_data && fifo_full && !fifo_pop) begin
      ovf_d  = 1'b1;
    end
  end

  // Frame sequencing, baud timing, bit counting and shifting.
  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    fifo_pop  = 1'b0;
    if (state_q != TX_IDLE) baud_d = bit_done ? '0 : baud_q + BW'(1);
    case (state_q)
      TX_IDLE: begin
        baud_d = '0;
        if (txen_q && !fifo_empty) begin
          fifo_pop  = 1'b1;
          shift_d   = fifo_dout;
          bit_cnt_d = '0;
          state_d   = TX_START;
        end
      end
      TX_START: begin
        if (bit_done) state_d = TX_DATA;
      end
      TX_DATA: begin
        if (bit_done) begin
          if (bit_cnt_q == 3'd7) begin
            state_d = TX_STOP;
          end else begin
            shift_d   = {1'b0, shift_q[7:1]};
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
      end
      TX_STOP: begin
        if (bit_done) begin
          if (txen_q && !fifo_empty) begin
            fifo_pop  = 1'b1;
            shift_d   = fifo_dout;
            bit_cnt_d = '0;
            state_d   = TX_START;
          end else begin
            state_d = TX_IDLE;
          end
        end
      end
      default: state_d = TX_IDLE;
    endcase
  end

  // Line level is registered from the next state so txd is glitch-free yet
  // still changes on the same edge as the state.
  always_comb begin
    case (state_d)
      TX_START: txd_d = 1'b0;
      TX_DATA:  txd_d = shift_d[0];
      default:  txd_d = 1'b1;
    endcase
  end

  // All control state; reset forces the line idle high immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      txen_q    <= 1'b0;
      ie_q      <= 1'b0;
      ovf_q     <= 1'b0;
      state_q   <= TX_IDLE;
      baud_q    <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      txd_q     <= 1'b1;
    end else begin
      txen_q    <= txen_d;
      ie_q      <= ie_d;
      ovf_q     <= ovf_d;
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      txd_q     <= txd_d;
    end
  end

  // Zero-wait-state register read mux.
  always_comb begin
    DataOut = '0;
    case (PrAddr)
      ADDR_STATUS: begin
        DataOut[STAT_BUSY]           = (state_q != TX_IDLE);
        DataOut[STAT_FULL]           = fifo_full;
        DataOut[STAT_EMPTY]          = fifo_empty;
        DataOut[STAT_OVF]            = ovf_q;
        DataOut[STAT_CNT_LSB +: 4]   = sat_count(32'(fifo_count));
      end
      ADDR_CTRL: begin
        DataOut[CTRL_TXEN] = txen_q;
        DataOut[CTRL_IE]   = ie_q;
      end
      default: DataOut = '0;
    endcase
  end

  assign InterruptRequest = ie_q && fifo_empty && (state_q == TX_IDLE);
  assign txd              = txd_q;

endmodule
